// File: rtl/wca_mod_counter.sv
// Modulo up/down counter with a programmable terminal value, wrap/saturate/one-shot
// modes, clock enable, start/stop control and a registered terminal-count strobe.
module wca_mod_counter #(
   parameter int WIDTH = 25
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ce,
   input  logic             start,
   input  logic             stop,
   input  logic             bUp,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             running,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_SAT     = 2'd1;
   localparam logic [1:0] MODE_ONESHOT = 2'd2;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             terminal;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   // Up uses >= so a limit lowered below the current count terminates on the next step.
   assign terminal = bUp ? (count_q >= limit) : (count_q == '0);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         count_d = (data > limit) ? limit : data;
         if (state_q == DONE) state_d = IDLE;
      end else if (stop && (state_q == RUN)) begin
         state_d = IDLE;
      end else if (start && (state_q != RUN)) begin
         state_d = RUN;
         if (state_q == DONE) count_d = bUp ? '0 : limit;
      end else if ((state_q == RUN) && ce) begin
         if (terminal) begin
            tc_d = 1'b1;
            case (mode)
               MODE_SAT:     count_d = bUp ? limit : '0;
               MODE_ONESHOT: state_d = DONE;
               default:      count_d = bUp ? '0 : limit;
            endcase
         end else begin
            count_d = bUp ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
         end
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign running = (state_q == RUN);
   assign done    = (state_q == DONE);

endmodule

// File: tb/tb_wca_mod_counter.sv
// Bench for wca_mod_counter: directed scenarios followed by random stimulus, all
// checked against a behavioural model of the counter rules.
module tb_wca_mod_counter;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic         ce, start, stop, bUp, load;
   logic [1:0]   mode;
   logic [W-1:0] data, limit;
   logic [W-1:0] count;
   logic         tc, running, done;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int unsigned m_cnt;
   bit          m_run, m_done, m_tc;

   wca_mod_counter #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .ce(ce), .start(start), .stop(stop),
      .bUp(bUp), .mode(mode), .load(load), .data(data), .limit(limit),
      .count(count), .tc(tc), .running(running), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_run = 0; m_done = 0; m_tc = 0;
   endtask

   // one clock edge of the counter rules, using the inputs present at the edge
   task automatic model_edge();
      bit term;
      m_tc = 0;
      if (reset) begin
         model_reset();
      end else if (load) begin
         m_cnt = (data > limit) ? limit : data;
         m_done = 0;
      end else if (stop && m_run) begin
         m_run = 0;
      end else if (start && !m_run) begin
         if (m_done) m_cnt = bUp ? 0 : limit;
         m_done = 0;
         m_run = 1;
      end else if (m_run && ce) begin
         term = bUp ? (m_cnt >= limit) : (m_cnt == 0);
         if (!term) begin
            m_cnt = bUp ? m_cnt + 1 : m_cnt - 1;
         end else begin
            m_tc = 1;
            if (mode == 2'd1) m_cnt = bUp ? limit : 0;
            else if (mode == 2'd2) begin m_run = 0; m_done = 1; end
            else m_cnt = bUp ? 0 : limit;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".count"},   32'(count),   m_cnt);
      chk({tag, ".tc"},      32'(tc),      32'(m_tc));
      chk({tag, ".running"}, 32'(running), 32'(m_run));
      chk({tag, ".done"},    32'(done),    32'(m_done));
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic idle_inputs();
      ce = 0; start = 0; stop = 0; load = 0;
   endtask

   initial begin
      int wrap_exp [10];
      int sat_exp [5];
      reset = 1; idle_inputs(); bUp = 1; mode = 0; data = 0; limit = 0;
      model_reset();
      #2;
      chk("reset.count", 32'(count), 0);
      chk("reset.tc", 32'(tc), 0);
      chk("reset.running", 32'(running), 0);
      chk("reset.done", 32'(done), 0);
      start = 1; ce = 1;
      tick("reset_held");
      reset = 0; idle_inputs();
      tick("reset_release");

      // wrap up, limit 4
      wrap_exp = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
      limit = 4; mode = 0; bUp = 1; start = 1; ce = 1;
      tick("wrap_start");
      chk("wrap_start.count", 32'(count), 0);
      chk("wrap_start.running", 32'(running), 1);
      start = 0;
      for (int i = 0; i < 10; i++) begin
         tick("wrap_step");
         chk("wrap.count_seq", 32'(count), wrap_exp[i]);
         chk("wrap.tc_seq", 32'(tc), (wrap_exp[i] == 0) ? 1 : 0);
      end

      // saturate down from 3 with a pause
      sat_exp = '{2, 1, 0, 0, 0};
      idle_inputs(); stop = 1;
      tick("sat_stop");
      stop = 0; load = 1; data = 3; mode = 1; bUp = 0;
      tick("sat_load");
      chk("sat_load.count", 32'(count), 3);
      load = 0; start = 1;
      tick("sat_start");
      start = 0; ce = 1;
      for (int i = 0; i < 5; i++) begin
         tick("sat_step");
         chk("sat.count_seq", 32'(count), sat_exp[i]);
         chk("sat.tc_seq", 32'(tc), (i >= 3) ? 1 : 0);
      end
      ce = 0;
      tick("sat_pause");
      chk("sat_pause.tc", 32'(tc), 0);
      chk("sat_pause.count", 32'(count), 0);

      // one-shot, limit 2, then rearm
      idle_inputs(); stop = 1;
      tick("os_stop");
      stop = 0; mode = 2; limit = 2; bUp = 1; start = 1;
      tick("os_start");
      start = 0; ce = 1;
      tick("os_step1");
      tick("os_step2");
      chk("os.count2", 32'(count), 2);
      tick("os_term");
      chk("os_term.done", 32'(done), 1);
      chk("os_term.running", 32'(running), 0);
      chk("os_term.tc", 32'(tc), 1);
      chk("os_term.count", 32'(count), 2);
      tick("os_after");
      chk("os_after.tc", 32'(tc), 0);
      start = 1;
      tick("os_rearm");
      chk("os_rearm.count", 32'(count), 0);
      chk("os_rearm.running", 32'(running), 1);
      start = 0;

      // load beats stop and step
      mode = 0; tick("prio_run");
      load = 1; data = 200; limit = 100; stop = 1; ce = 1;
      tick("prio_load");
      chk("prio_load.count", 32'(count), 100);
      chk("prio_load.running", 32'(running), 1);
      load = 0;
      tick("prio_stop");
      chk("prio_stop.running", 32'(running), 0);
      chk("prio_stop.count", 32'(count), 100);

      // limit shrink while counting up
      idle_inputs(); load = 1; data = 50;
      tick("shrink_load");
      load = 0; start = 1;
      tick("shrink_start");
      start = 0; limit = 10; ce = 1;
      tick("shrink_step");
      chk("shrink.count", 32'(count), 0);
      chk("shrink.tc", 32'(tc), 1);

      // asynchronous reset between edges
      tick("areset_pre");
      #2 reset = 1;
      model_reset();
      #1;
      chk("areset.count", 32'(count), 0);
      chk("areset.running", 32'(running), 0);
      chk("areset.tc", 32'(tc), 0);
      tick("areset_held");
      reset = 0;
      for (int i = 0; i < 3; i++) tick("areset_idle");
      chk("areset_idle.running", 32'(running), 0);
      start = 1;
      tick("areset_start");
      start = 0;

      // random stimulus, limit=0 included
      for (int i = 0; i < 3000; i++) begin
         ce    = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 31) == 0);
         load  = ($urandom_range(0, 15) == 0);
         data  = W'($urandom_range(0, 255));
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) bUp = ~bUp;
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 2))
               0: limit = 0;
               1: limit = W'($urandom_range(1, 7));
               default: limit = W'($urandom_range(0, 255));
            endcase
         end
         tick("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
